// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frames symbols into a Viterbi decoder, flushes it, trims decoded output.
// Define VITERBI_CTRL_TIMEOUT_EN to add the DRAIN watchdog that reports err.
module viterbi_frame_ctrl #(
  parameter int TBLEN   = 32,
  parameter int LEN_W   = 11,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_frame_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_sym,
  output logic             dec_RSTn,
  output logic             dec_in_valid,
  output logic [1:0]       dec_in,
  input  logic             dec_out_valid,
  input  logic             dec_out,
  output logic             m_valid,
  output logic             m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] len, in_cnt, out_cnt, fl_cnt;
  logic acc, take, wd_hit;
  assign s_ready  = state == FEED;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign dec_RSTn = RSTn && state != CLEAR;
  assign acc      = s_valid && s_ready;
  assign take     = dec_out_valid && busy && !done && out_cnt < len;
`ifdef VITERBI_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic err_q;
  assign wd_hit = state == DRAIN && out_cnt != len && wd_cnt == WD_W'(TIMEOUT - 1);
  assign err    = err_q;
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == DRAIN && !dec_out_valid) ? wd_cnt + 1'b1 : '0;
      err_q  <= wd_hit;
    end
  end
`else
  assign wd_hit = 1'b0;
  // no watchdog: err can never fire
  assign err    = TIMEOUT < 0;
`endif
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = cfg_frame_len != '0 ? CLEAR : DONE;
      CLEAR:   state_nx = FEED;
      FEED:    if (acc && in_cnt == len - 1'b1) state_nx = FLUSH;
      FLUSH:   if (fl_cnt == LEN_W'(TBLEN - 1)) state_nx = DRAIN;
      DRAIN:   if (out_cnt == len || wd_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state        <= IDLE;
      len          <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      fl_cnt       <= '0;
      dec_in_valid <= 1'b0;
      dec_in       <= 2'b00;
      m_valid      <= 1'b0;
      m_data       <= 1'b0;
      m_last       <= 1'b0;
    end else begin
      state        <= state_nx;
      len          <= (state == IDLE && start) ? cfg_frame_len : len;
      in_cnt       <= state == CLEAR ? '0 : in_cnt + LEN_W'(acc);
      fl_cnt       <= state == FLUSH ? fl_cnt + 1'b1 : '0;
      out_cnt      <= (state == IDLE && start) ? '0 : out_cnt + LEN_W'(take);
      dec_in_valid <= acc || state == FLUSH;
      dec_in       <= acc ? s_sym : 2'b00;
      m_valid      <= take;
      m_data       <= take && dec_out;
      m_last       <= take && out_cnt == len - 1'b1;
    end
  end
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: table-driven frames through a stand-in decoder plus corner-case sequences.
module tb_viterbi_frame_ctrl;
  localparam int TBLEN = 32;
  localparam int LEN_W = 11;
  localparam int TO    = 20;
  logic clk, RSTn, start, s_valid, s_ready, dec_RSTn, dec_in_valid, dec_out_valid, dec_out;
  logic m_valid, m_data, m_last, busy, done, err;
  logic [LEN_W-1:0] cfg_frame_len;
  logic [1:0] s_sym, dec_in;
  viterbi_frame_ctrl #(.TBLEN(TBLEN), .LEN_W(LEN_W), .TIMEOUT(TO)) dut (
    .clk(clk), .RSTn(RSTn), .start(start), .cfg_frame_len(cfg_frame_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_sym(s_sym), .dec_RSTn(dec_RSTn),
    .dec_in_valid(dec_in_valid), .dec_in(dec_in), .dec_out_valid(dec_out_valid),
    .dec_out(dec_out), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // stand-in decoder: emits sym[1]^sym[0] for every input symbol, lat+1 cycles later
  logic [63:0] pv, pd;
  int lat;
  logic ov_force, od_force, dec_en;
  always @(posedge clk) begin
    if (!dec_RSTn) begin
      pv <= '0;
      pd <= '0;
    end else begin
      pv <= {pv[62:0], dec_in_valid};
      pd <= {pd[62:0], dec_in[1] ^ dec_in[0]};
    end
  end
  assign dec_out_valid = ov_force | (dec_en & pv[lat]);
  assign dec_out       = ov_force ? od_force : pd[lat];
  bit got[$];
  logic [1:0] din[$];
  int ndone, nclr, nlast, last_idx, idle_mv, nerrp;
  always @(negedge clk) begin
    if (m_valid) got.push_back(m_data);
    if (m_valid && m_last) begin
      nlast++;
      last_idx = got.size() - 1;
    end
    if (done) ndone++;
    if (err) nerrp++;
    if (RSTn && !dec_RSTn) nclr++;
    if (dec_in_valid) din.push_back(dec_in);
    if (m_valid && !busy) idle_mv++;
  end
  int nchk, nerrs;
  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  typedef struct {
    int len;
    bit gap;
    int lat;
    bit restart;
    int exp_vin;
    int exp_last;
  } vec_t;
  vec_t tbl[4];
  logic [1:0] syms[64];
  task automatic clear_mon();
    got.delete();
    din.delete();
    ndone = 0; nclr = 0; nlast = 0; last_idx = -1;
  endtask
  task automatic feed(input vec_t v);
    int idx = 0, cyc = 0;
    @(negedge clk);
    start = 1'b1;
    cfg_frame_len = LEN_W'(v.len);
    @(negedge clk);
    while (idx < v.len && cyc < 1000) begin
      start = v.restart && cyc == 4;
      cfg_frame_len = start ? LEN_W'(3) : LEN_W'(v.len);
      s_valid = !(v.gap && cyc % 3 == 2);
      s_sym = syms[idx];
      if (s_valid && s_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("feed_accepts", idx, v.len);
  endtask
  task automatic run_frame(input vec_t v);
    int guard = 0, bad = 0;
    clear_mon();
    lat = v.lat;
    dec_en = 1'b1;
    feed(v);
    while (!done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", int'(done), 1);
    repeat (70) @(negedge clk);
    chk("m_cnt", got.size(), v.len);
    for (int i = 0; i < got.size() && i < v.len; i++)
      if (got[i] !== (syms[i][1] ^ syms[i][0])) bad++;
    chk("m_data_bad", bad, 0);
    chk("m_last_idx", last_idx, v.exp_last);
    chk("m_last_cnt", nlast, 1);
    chk("dec_in_cnt", din.size(), v.exp_vin);
    bad = 0;
    for (int i = 0; i < din.size(); i++)
      if (din[i] !== (i < v.len ? syms[i] : 2'b00)) bad++;
    chk("dec_in_bad", bad, 0);
    chk("clr_cycles", nclr, 1);
    chk("done_cnt", ndone, 1);
    chk("busy_after", int'(busy), 0);
  endtask
  initial begin
    vec_t v;
    int t, last_v, guard;
    nchk = 0; nerrs = 0; nerrp = 0; idle_mv = 0;
    RSTn = 1'b0; start = 1'b0; s_valid = 1'b0; s_sym = 2'b00; cfg_frame_len = '0;
    ov_force = 1'b0; od_force = 1'b0; dec_en = 1'b0; lat = 0;
    for (int i = 0; i < 64; i++) syms[i] = 2'($urandom_range(0, 3));
    tbl[0] = '{len: 32, gap: 0, lat: 3,  restart: 0, exp_vin: 64, exp_last: 31};
    tbl[1] = '{len: 32, gap: 1, lat: 45, restart: 1, exp_vin: 64, exp_last: 31};
    tbl[2] = '{len: 1,  gap: 0, lat: 45, restart: 0, exp_vin: 33, exp_last: 0};
    tbl[3] = '{len: 5,  gap: 1, lat: 0,  restart: 0, exp_vin: 37, exp_last: 4};
    repeat (3) @(negedge clk);
    chk("rst_outs", int'({s_ready, dec_in_valid, dec_in, m_valid, m_data, m_last, busy, done, err}), 0);
    chk("rst_dec_RSTn", int'(dec_RSTn), 0);
    RSTn = 1'b1;
    @(negedge clk);
    chk("idle_dec_RSTn", int'(dec_RSTn), 1);
    chk("idle_busy", int'(busy), 0);
    for (int k = 0; k < 4; k++) run_frame(tbl[k]);
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    cfg_frame_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done", int'(done), 1);
    chk("len0_busy", int'(busy), 1);
    @(negedge clk);
    chk("len0_done_end", int'({done, busy}), 0);
    repeat (3) @(negedge clk);
    chk("len0_clr", nclr, 0);
    chk("len0_din", din.size(), 0);
    chk("len0_done_cnt", ndone, 1);
    clear_mon();
    ov_force = 1'b1;
    od_force = 1'b1;
    repeat (4) @(negedge clk);
    ov_force = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_decout_m", got.size(), 0);
    chk("idle_decout_busy", int'(busy), 0);
    clear_mon();
    v = '{len: 4, gap: 0, lat: 45, restart: 0, exp_vin: 36, exp_last: 3};
    lat = v.lat;
    dec_en = 1'b1;
    feed(v);
    repeat (5) @(negedge clk);
    chk("pre_rst_flush", int'({busy, dec_in_valid, s_ready}), 3'b110);
    RSTn = 1'b0;
    @(negedge clk);
    chk("midrst_outs", int'({s_ready, dec_in_valid, dec_in, m_valid, m_data, m_last, busy, done, err}), 0);
    chk("midrst_dec_RSTn", int'(dec_RSTn), 0);
    RSTn = 1'b1;
    repeat (80) @(negedge clk);
    chk("midrst_no_done", ndone, 0);
    chk("midrst_idle", int'(busy), 0);
`ifdef VITERBI_CTRL_TIMEOUT_EN
    clear_mon();
    lat = 0;
    dec_en = 1'b0;
    feed(v);
    t = 0; last_v = -1000; guard = 0;
    while (!done && guard < 500) begin
      @(negedge clk);
      t++;
      guard++;
      if (dec_in_valid) last_v = t;
    end
    chk("wd_latency", t - last_v, TO);
    chk("wd_err", int'({err, done}), 3);
    chk("wd_no_mlast", nlast, 0);
    @(negedge clk);
    chk("wd_idle", int'({err, done, busy}), 0);
    dec_en = 1'b1;
    chk("err_pulses", nerrp, 1);
`else
    chk("err_pulses", nerrp, 0);
`endif
    chk("idle_mvalid", idle_mv, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerrs);
    $finish;
  end
endmodule
